div_ctrl: RTL and testbench

- Sequencer for an iterative 32-bit radix-2 restoring divider in the EX stage. Serves DIV/DIVU.
- EX starts the divider and holds start_i while it consumes busy_o as its stall request to the pipeline controller.
- On completion, EX takes result_o and writes it to HI/LO (HI = remainder, LO = quotient) through its existing whilo/hi/lo outputs.

---
 rtl/div_if.sv | 19 +
 rtl/div_ctrl.sv | 107 ++++++++++
 tb/tb_div_ctrl.sv | 130 +++++++++++++
 3 files changed

// File: rtl/div_if.sv
// div_if: EX-stage handshake and operand/result bundle for the iterative divider
interface div_if #(parameter int DATA_W = 32);
  logic                  signed_div_i;
  logic [DATA_W-1:0]     opdata1_i;
  logic [DATA_W-1:0]     opdata2_i;
  logic                  start_i;
  logic                  annul_i;
  logic [2*DATA_W-1:0]   result_o;
  logic                  ready_o;
  logic                  busy_o;
  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o, busy_o
  );
  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o, busy_o
  );
endinterface

// File: rtl/div_ctrl.sv
// div_ctrl: sequencer for a radix-2 restoring divider returning {remainder, quotient}
module div_ctrl #(parameter int DATA_W = 32) (
  input  logic   clk,
  input  logic   rst,
  div_if.slave   bus
);
  typedef enum logic [1:0] {IDLE, BYZERO, ON, END} state_t;
  state_t                state_q, state_d;
  logic [5:0]            count_q, count_d;
  logic [2*DATA_W:0]     work_q, work_d;
  logic [DATA_W-1:0]     div_q, div_d;
  logic                  sgn_q, sgn_d;
  logic                  s1_q, s1_d;
  logic                  s2_q, s2_d;
  logic [2*DATA_W-1:0]   result_q, result_d;
  logic                  ready_q, ready_d;
  logic [DATA_W:0]       diff;
  logic [DATA_W-1:0]     mag1, mag2, quo, rem;
  assign mag1 = (bus.signed_div_i && bus.opdata1_i[DATA_W-1]) ? -bus.opdata1_i : bus.opdata1_i;
  assign mag2 = (bus.signed_div_i && bus.opdata2_i[DATA_W-1]) ? -bus.opdata2_i : bus.opdata2_i;
  assign diff = work_q[2*DATA_W:DATA_W] - {1'b0, div_q};
  assign quo  = (sgn_q && (s1_q ^ s2_q)) ? -work_q[DATA_W-1:0] : work_q[DATA_W-1:0];
  assign rem  = (sgn_q && s1_q) ? -work_q[2*DATA_W:DATA_W+1] : work_q[2*DATA_W:DATA_W+1];
  assign bus.result_o = result_q;
  assign bus.ready_o  = ready_q;
  assign bus.busy_o   = bus.start_i & ~ready_q;
  // next-state: operand capture in IDLE, one quotient bit per cycle in ON, hold in END
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    work_d   = work_q;
    div_d    = div_q;
    sgn_d    = sgn_q;
    s1_d     = s1_q;
    s2_d     = s2_q;
    result_d = result_q;
    ready_d  = ready_q;
    unique case (state_q)
      IDLE: begin
        ready_d  = 1'b0;
        result_d = '0;
        if (bus.start_i && !bus.annul_i) begin
          if (bus.opdata2_i == '0) state_d = BYZERO;
          else begin
            state_d = ON;
            count_d = '0;
            div_d   = mag2;
            work_d  = {{(DATA_W+1){1'b0}}, mag1, 1'b0};
            sgn_d   = bus.signed_div_i;
            s1_d    = bus.opdata1_i[DATA_W-1];
            s2_d    = bus.opdata2_i[DATA_W-1];
          end
        end
      end
      BYZERO: begin
        state_d  = bus.annul_i ? IDLE : END;
        ready_d  = ~bus.annul_i;
        result_d = '0;
      end
      ON: begin
        if (bus.annul_i) begin
          state_d = IDLE;
          ready_d = 1'b0;
        end else if (count_q != 6'(DATA_W)) begin
          work_d  = diff[DATA_W] ? {work_q[2*DATA_W-1:0], 1'b0}
                                 : {diff[DATA_W-1:0], work_q[DATA_W-1:0], 1'b1};
          count_d = count_q + 6'd1;
        end else begin
          result_d = {rem, quo};
          ready_d  = 1'b1;
          state_d  = END;
        end
      end
      END: begin
        if (!bus.start_i) begin
          state_d  = IDLE;
          ready_d  = 1'b0;
          result_d = '0;
        end
      end
    endcase
  end
  // state registers; reset returns to IDLE with outputs cleared
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      count_q  <= '0;
      work_q   <= '0;
      div_q    <= '0;
      sgn_q    <= 1'b0;
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      result_q <= '0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      work_q   <= work_d;
      div_q    <= div_d;
      sgn_q    <= sgn_d;
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      result_q <= result_d;
      ready_q  <= ready_d;
    end
  end
endmodule

// File: tb/tb_div_ctrl.sv
// tb_div_ctrl: directed vector table plus annul/reset sequences for div_ctrl
module tb_div_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_chk = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  div_if #(.DATA_W(32)) bus ();
  div_ctrl #(.DATA_W(32)) dut (.clk(clk), .rst(rst), .bus(bus));
  typedef struct {
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
  } vec_t;
  vec_t v[11];
  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask
  task automatic run_div(input vec_t t, input bit scramble);
    int n;
    int lat;
    lat = (t.b == 0) ? 2 : 34;
    bus.signed_div_i = t.sgn;
    bus.opdata1_i = t.a;
    bus.opdata2_i = t.b;
    bus.annul_i = 1'b0;
    bus.start_i = 1'b1;
    #1;
    check("busy_at_start", 64'(bus.busy_o), 64'd1);
    n = 0;
    while (n < 40) begin
      @(posedge clk);
      #1;
      n++;
      if (scramble && n == 1) begin
        bus.opdata1_i = ~t.a;
        bus.opdata2_i = t.b + 32'd5;
        bus.signed_div_i = ~t.sgn;
      end
      if (bus.ready_o) break;
    end
    check("latency", 64'(n), 64'(lat));
    check("result", bus.result_o, {t.r, t.q});
    check("busy_done", 64'(bus.busy_o), 64'd0);
    bus.annul_i = 1'b1;
    @(posedge clk);
    #1;
    check("end_hold_ready", 64'(bus.ready_o), 64'd1);
    check("end_hold_result", bus.result_o, {t.r, t.q});
    bus.annul_i = 1'b0;
    bus.start_i = 1'b0;
    @(posedge clk);
    #1;
    check("drop_ready", 64'(bus.ready_o), 64'd0);
    check("drop_result", bus.result_o, 64'd0);
  endtask
  task automatic idle_watch(input string name);
    logic seen;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      seen |= bus.ready_o;
    end
    check(name, 64'(seen), 64'd0);
  endtask
  initial begin
    v[0]  = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2};
    v[1]  = '{1'b1, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   32'hFFFFFFFF};
    v[2]  = '{1'b1, 32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD,   32'h00000001};
    v[3]  = '{1'b0, 32'hFFFFFFF9,   32'd2,          32'h7FFFFFFC,   32'd1};
    v[4]  = '{1'b1, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'd0};
    v[5]  = '{1'b0, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   32'd0};
    v[6]  = '{1'b1, 32'hFFFFFF9C,   32'd7,          32'hFFFFFFF2,   32'hFFFFFFFE};
    v[7]  = '{1'b0, 32'h80000000,   32'hFFFFFFFF,   32'd0,          32'h80000000};
    v[8]  = '{1'b0, 32'd5,          32'd0,          32'd0,          32'd0};
    v[9]  = '{1'b1, 32'hFFFFFFF9,   32'd0,          32'd0,          32'd0};
    v[10] = '{1'b0, 32'd3,          32'd10,         32'd0,          32'd3};
    bus.signed_div_i = 1'b0;
    bus.opdata1_i = '0;
    bus.opdata2_i = '0;
    bus.start_i = 1'b0;
    bus.annul_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_ready", 64'(bus.ready_o), 64'd0);
    check("reset_result", bus.result_o, 64'd0);
    check("reset_busy", 64'(bus.busy_o), 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    foreach (v[i]) run_div(v[i], 1'b0);
    run_div(v[0], 1'b1);
    bus.signed_div_i = 1'b0;
    bus.opdata1_i = 32'd100;
    bus.opdata2_i = 32'd7;
    bus.start_i = 1'b1;
    repeat (11) @(posedge clk);
    #1;
    bus.annul_i = 1'b1;
    bus.start_i = 1'b0;
    @(posedge clk);
    #1;
    check("annul_ready", 64'(bus.ready_o), 64'd0);
    check("annul_result", bus.result_o, 64'd0);
    bus.annul_i = 1'b0;
    idle_watch("annul_no_ready");
    run_div(v[0], 1'b0);
    bus.start_i = 1'b1;
    repeat (21) @(posedge clk);
    #1;
    rst = 1'b1;
    bus.start_i = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_ready", 64'(bus.ready_o), 64'd0);
    check("midrst_result", bus.result_o, 64'd0);
    rst = 1'b0;
    idle_watch("midrst_no_ready");
    run_div(v[0], 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
